// File: rtl/ws2812_bit_decoder_if.sv
// Pixel-side bus of the WS2812B bit decoder: recovered pixel word plus frame/error strobes.
interface ws2812_bit_decoder_if #(
  parameter int IDX_W = 8
);
  logic [23:0]      pixel;
  logic             pixelValid;
  logic [IDX_W-1:0] pixelIdx;
  logic             frameDone;
  logic             err;

  modport master (output pixel, pixelValid, pixelIdx, frameDone, err);
  modport slave  (input  pixel, pixelValid, pixelIdx, frameDone, err);
endinterface

// File: rtl/ws2812_bit_decoder.sv
// WS2812B NZR receiver: pulse-width bit recovery, 24-bit GRB assembly and RET detection.
// Define WS2812_FWD_EN to add chip-style pass-through of the line on dataOut.
module ws2812_bit_decoder #(
  parameter int GLITCH_MAX = 10,
  parameter int ONE_THRESH = 60,
  parameter int HIGH_MAX   = 100,
  parameter int RET_CYCLES = 5000,
  parameter int IDX_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dataIn,
  output logic                  dataOut,
  ws2812_bit_decoder_if.master  pixBus
);

  localparam int HCW = $clog2(HIGH_MAX + 2);
  localparam int LCW = $clog2(RET_CYCLES + 1);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t           state;
  state_t           priorState;
  logic             d1;
  logic             dSync;
  logic [HCW-1:0]   highCnt;
  logic [LCW-1:0]   lowCnt;
  logic [22:0]      shiftReg;
  logic [4:0]       bitCnt;
  logic [IDX_W-1:0] frameCnt;
  logic             bitVal;

  assign bitVal = (highCnt >= HCW'(ONE_THRESH));

  // States track the synchronised line level, so a level change seen in HIGH/LOW is the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d1                <= 1'b0;
      dSync             <= 1'b0;
      state             <= SYNC;
      priorState        <= IDLE;
      highCnt           <= '0;
      lowCnt            <= '0;
      shiftReg          <= '0;
      bitCnt            <= '0;
      frameCnt          <= '0;
      pixBus.pixel      <= '0;
      pixBus.pixelValid <= 1'b0;
      pixBus.pixelIdx   <= '0;
      pixBus.frameDone  <= 1'b0;
      pixBus.err        <= 1'b0;
    end else begin
      d1                <= dataIn;
      dSync             <= d1;
      pixBus.pixelValid <= 1'b0;
      pixBus.frameDone  <= 1'b0;
      pixBus.err        <= 1'b0;
      case (state)
        SYNC: begin
          bitCnt   <= '0;
          shiftReg <= '0;
          if (dSync) begin
            lowCnt <= '0;
          end else if (lowCnt >= LCW'(RET_CYCLES - 1)) begin
            lowCnt <= '0;
            state  <= IDLE;
          end else begin
            lowCnt <= lowCnt + 1'b1;
          end
        end
        IDLE: begin
          bitCnt   <= '0;
          shiftReg <= '0;
          frameCnt <= '0;
          if (dSync) begin
            state      <= HIGH;
            highCnt    <= HCW'(1);
            priorState <= IDLE;
          end
        end
        HIGH: begin
          if (dSync) begin
            if (highCnt >= HCW'(HIGH_MAX)) begin
              pixBus.err <= 1'b1;
              lowCnt     <= '0;
              state      <= SYNC;
            end else begin
              highCnt <= highCnt + 1'b1;
            end
          end else if (highCnt < HCW'(GLITCH_MAX)) begin
            // Glitch: drop the pulse and resume as if it never happened.
            pixBus.err <= 1'b1;
            state      <= priorState;
          end else begin
            state  <= LOW;
            lowCnt <= LCW'(1);
            if (bitCnt == 5'd23) begin
              pixBus.pixel      <= {shiftReg, bitVal};
              pixBus.pixelValid <= 1'b1;
              pixBus.pixelIdx   <= frameCnt;
              bitCnt            <= '0;
              if (frameCnt != '1) frameCnt <= frameCnt + 1'b1;
            end else begin
              shiftReg <= {shiftReg[21:0], bitVal};
              bitCnt   <= bitCnt + 5'd1;
            end
          end
        end
        LOW: begin
          if (dSync) begin
            state      <= HIGH;
            highCnt    <= HCW'(1);
            priorState <= LOW;
          end else if (lowCnt == LCW'(RET_CYCLES)) begin
            pixBus.frameDone <= 1'b1;
            pixBus.err       <= (bitCnt != 5'd0);
            state            <= IDLE;
          end else begin
            lowCnt <= lowCnt + 1'b1;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

`ifdef WS2812_FWD_EN
  logic fwdActive;

  // Pass-through opens once the first pixel of a frame is consumed and closes at RET or resync.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwdActive <= 1'b0;
      dataOut   <= 1'b0;
    end else begin
      if (pixBus.frameDone || state == SYNC) fwdActive <= 1'b0;
      else if (pixBus.pixelValid)            fwdActive <= 1'b1;
      dataOut <= fwdActive & dSync;
    end
  end
`else
  assign dataOut = 1'b0;
`endif

endmodule
